// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: sequences a downstream Montgomery
// multiplier through left-to-right square-and-multiply to form C = M^E mod N.
// Conversion into the Montgomery domain uses the precomputed R^2 mod N and
// conversion out is a final multiply by 1. Every exponent bit is processed,
// leading zeros included, so the multiplication count depends only on W and
// popcount(E).
module modexp_ctrl #(
    parameter int W  = 2048,
    parameter int CW = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] M,
    input  logic [W-1:0] E,
    input  logic [W-1:0] N,
    input  logic [W-1:0] R2,
    output logic [W-1:0] C,
    output logic         done,
    output logic         busy,
    output logic         mm_start,
    output logic [W-1:0] mm_x,
    output logic [W-1:0] mm_y,
    output logic [W-1:0] mm_n,
    input  logic [W-1:0] mm_o,
    input  logic         mm_done
);

    typedef enum logic [2:0] {
        IDLE,
        TOM,
        TOA,
        SQR,
        MUL,
        FROM,
        FIN
    } state_t;

    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [CW-1:0] TOP_I = CW'(W - 1);

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  m_r;
    logic [W-1:0]  e_r;
    logic [W-1:0]  n_r;
    logic [W-1:0]  r2_r;
    logic [W-1:0]  mbar;
    logic [W-1:0]  a;
    logic [CW-1:0] i;
    logic          pending;

    // Control decodes produced by the next-state logic
    logic          ack;
    logic          issue;
    logic          capture;
    logic          i_load;
    logic          i_dec;
    logic          lat_mbar;
    logic          lat_a;
    logic          lat_c;
    logic [W-1:0]  e_sh;
    logic          e_bit;

    // Only a completion for an outstanding multiplication advances the FSM;
    // stray pulses (idle, or left over from an aborted run) are dropped.
    assign ack   = pending && mm_done;

    // Current exponent bit, selected by shifting so the index width need not
    // match the exponent width.
    assign e_sh  = e_r >> i;
    assign e_bit = e_sh[0];

    assign busy  = (state != IDLE);
    assign done  = (state == FIN);
    assign mm_n  = n_r;

    // Operand selection: sourced only from registers that do not change while
    // a multiplication is pending, so the operands stay stable until mm_done.
    always_comb begin
        mm_x = '0;
        mm_y = '0;
        case (state)
            TOM:     begin mm_x = m_r; mm_y = r2_r; end
            TOA:     begin mm_x = ONE; mm_y = r2_r; end
            SQR:     begin mm_x = a;   mm_y = a;    end
            MUL:     begin mm_x = a;   mm_y = mbar; end
            FROM:    begin mm_x = a;   mm_y = ONE;  end
            default: begin mm_x = '0;  mm_y = '0;   end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-transition control decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        i_load     = 1'b0;
        i_dec      = 1'b0;
        lat_mbar   = 1'b0;
        lat_a      = 1'b0;
        lat_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    issue      = 1'b1;
                    state_next = TOM;
                end
            end
            TOM: begin
                if (ack) begin
                    lat_mbar   = 1'b1;
                    issue      = 1'b1;
                    state_next = TOA;
                end
            end
            TOA: begin
                if (ack) begin
                    lat_a      = 1'b1;
                    i_load     = 1'b1;
                    issue      = 1'b1;
                    state_next = SQR;
                end
            end
            SQR: begin
                if (ack) begin
                    lat_a = 1'b1;
                    issue = 1'b1;
                    if (e_bit) begin
                        state_next = MUL;
                    end else if (i == '0) begin
                        state_next = FROM;
                    end else begin
                        // Re-entering SQR for the next lower bit
                        i_dec      = 1'b1;
                        state_next = SQR;
                    end
                end
            end
            MUL: begin
                if (ack) begin
                    lat_a = 1'b1;
                    issue = 1'b1;
                    if (i == '0) begin
                        state_next = FROM;
                    end else begin
                        i_dec      = 1'b1;
                        state_next = SQR;
                    end
                end
            end
            FROM: begin
                if (ack) begin
                    lat_c      = 1'b1;
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, intermediate results, bit index,
    // multiplier handshake tracking
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; all datapath registers, not just the
        // FSM, are cleared so an aborted run leaves no stale values behind.
        if (!rst_n) begin
            m_r      <= '0;
            e_r      <= '0;
            n_r      <= '0;
            r2_r     <= '0;
            mbar     <= '0;
            a        <= '0;
            C        <= '0;
            i        <= '0;
            pending  <= 1'b0;
            mm_start <= 1'b0;
        end else begin
            mm_start <= issue;
            pending  <= issue || (pending && !mm_done);
            if (capture) begin
                m_r  <= M;
                e_r  <= E;
                n_r  <= N;
                r2_r <= R2;
            end
            if (lat_mbar) mbar <= mm_o;
            if (lat_a)    a    <= mm_o;
            if (lat_c)    C    <= mm_o;
            if (i_load) begin
                i <= TOP_I;
            end else if (i_dec) begin
                i <= i - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl at W=8. A behavioural Montgomery multiplier with
// random latency answers the controller; results are compared with plain
// modular exponentiation and the multiplication count W + popcount(E) + 3.
module tb_modexp_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] M, E, N, R2;
    logic [W-1:0] C;
    logic         done, busy, mm_start;
    logic [W-1:0] mm_x, mm_y, mm_n;
    logic [W-1:0] mm_o;
    logic         mm_done;

    modexp_ctrl #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .M        (M),
        .E        (E),
        .N        (N),
        .R2       (R2),
        .C        (C),
        .done     (done),
        .busy     (busy),
        .mm_start (mm_start),
        .mm_x     (mm_x),
        .mm_y     (mm_y),
        .mm_n     (mm_n),
        .mm_o     (mm_o),
        .mm_done  (mm_done)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Multiplier model state and monitors
    int           start_count = 0;
    int           done_count  = 0;
    int           stab_err    = 0;
    int           lat_fixed   = 0;
    logic         mdl_pend    = 1'b0;
    int           mdl_cnt     = 0;
    logic [W-1:0] cap_x, cap_y, cap_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Montgomery product by definition: the k in [0,n) with k*R = x*y (mod n)
    function automatic logic [W-1:0] mm_fn(input int x, input int y, input int n);
        int target;
        target = (x * y) % n;
        for (int k = 0; k < n; k++) begin
            if (((k * 256) % n) == target) return W'(k);
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] ref_modexp(input int m, input int e, input int n);
        int acc;
        acc = 1 % n;
        for (int k = 0; k < e; k++) acc = (acc * m) % n;
        return W'(acc);
    endfunction

    // Behavioural Montgomery multiplier with 1..40 cycle latency
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (mdl_pend) begin
            if (mm_x !== cap_x || mm_y !== cap_y || mm_n !== cap_n) stab_err++;
            if (mdl_cnt == 0) begin
                mm_done  = 1'b1;
                mm_o     = mm_fn(int'(cap_x), int'(cap_y), int'(cap_n));
                mdl_pend = 1'b0;
            end else begin
                mdl_cnt--;
            end
        end
        if (mm_start) begin
            start_count++;
            cap_x    = mm_x;
            cap_y    = mm_y;
            cap_n    = mm_n;
            mdl_pend = 1'b1;
            mdl_cnt  = (lat_fixed > 0) ? lat_fixed - 1 : int'($urandom_range(39, 0));
        end
    end

    // done pulse monitor
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    // One request: pulse start, optionally re-pulse start with M=7 while
    // busy, wait (bounded) for done, then step into the following idle cycle.
    task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                          input logic [W-1:0] n, input logic [W-1:0] r2,
                          input logic [W-1:0] exp_c, input int exp_mults, input int repulse_at);
        int s0, d0, st0, cyc;
        logic [W-1:0] c_got;
        s0  = start_count;
        d0  = done_count;
        st0 = stab_err;
        M = m; E = e; N = n; R2 = r2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        if (repulse_at > 0) begin
            repeat (repulse_at) @(negedge clk);
            M = 8'd7;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " no_timeout"}, 64'(cyc < 20000), 64'd1);
        c_got = C;
        @(negedge clk);
        check({tag, " C"}, 64'(c_got), 64'(exp_c));
        check({tag, " mults"}, 64'(start_count - s0), 64'(exp_mults));
        check({tag, " done_pulses"}, 64'(done_count - d0), 64'd1);
        check({tag, " idle_after_done"}, 64'(busy), 64'd0);
        check({tag, " operands_stable"}, 64'(stab_err - st0), 64'd0);
        check({tag, " mm_n"}, 64'(mm_n), 64'(n));
    endtask

    typedef struct {
        logic [W-1:0] m, e, n, r2, c;
        int           mults;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int d0, cyc;
        int rn, rm, re, rr;

        tbl[0] = '{m: 8'd5,  e: 8'd3,    n: 8'd13, r2: 8'd3, c: 8'd8,  mults: 13};
        tbl[1] = '{m: 8'd5,  e: 8'd0,    n: 8'd13, r2: 8'd3, c: 8'd1,  mults: 11};
        tbl[2] = '{m: 8'd0,  e: 8'hFF,   n: 8'd13, r2: 8'd3, c: 8'd0,  mults: 19};
        tbl[3] = '{m: 8'd2,  e: 8'd5,    n: 8'd13, r2: 8'd3, c: 8'd6,  mults: 13};
        tbl[4] = '{m: 8'd12, e: 8'd1,    n: 8'd13, r2: 8'd3, c: 8'd12, mults: 12};
        tbl[5] = '{m: 8'd3,  e: 8'd2,    n: 8'd7,  r2: 8'd2, c: 8'd2,  mults: 12};
        tbl[6] = '{m: 8'd1,  e: 8'hFF,   n: 8'd11, r2: 8'd9, c: 8'd1,  mults: 19};

        rst_n = 1'b0; start = 1'b0;
        M = '0; E = '0; N = '0; R2 = '0;
        mm_o = '0; mm_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset C", 64'(C), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset mm_start", 64'(mm_start), 64'd0);
        check("reset mm_x", 64'(mm_x), 64'd0);
        check("reset mm_y", 64'(mm_y), 64'd0);
        check("reset mm_n", 64'(mm_n), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, back to back: each start lands in the cycle after done
        foreach (tbl[k]) begin
            run_op($sformatf("vec%0d", k), tbl[k].m, tbl[k].e, tbl[k].n, tbl[k].r2,
                   tbl[k].c, tbl[k].mults, 0);
        end

        // start re-pulsed with M=7 while busy is ignored
        run_op("repulse", 8'd5, 8'd3, 8'd13, 8'd3, 8'd8, 13, 6);

        // Reset during SQR, then a stray mm_done from the aborted multiply
        lat_fixed = 30;
        d0 = done_count;
        M = 8'd5; E = 8'd3; N = 8'd13; R2 = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (start_count < d0 * 0 + 1000000 && cyc < 2000) begin
            if (mdl_pend && mdl_cnt < 28 && cyc > 0 && busy === 1'b1 && start_count >= 0) begin
                // wait handled below
            end
            @(negedge clk);
            cyc++;
            if (cyc >= 2 * 30 + 12) break;
        end
        // Two 30-cycle multiplies (TOM, TOA) completed; now inside the first SQR
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort mm_start", 64'(mm_start), 64'd0);
        check("abort pending_mult", 64'(mdl_pend), 64'd1);
        cyc = 0;
        while (mdl_pend && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("abort stray_done_seen", 64'(cyc < 100), 64'd1);
        check("abort no_done", 64'(done_count - d0), 64'd0);
        check("abort still_idle", 64'(busy), 64'd0);
        check("abort C", 64'(C), 64'd0);
        lat_fixed = 0;
        run_op("after_abort", 8'd2, 8'd5, 8'd13, 8'd3, 8'd6, 13, 0);

        // Randomized requests against the arithmetic reference
        for (int t = 0; t < 20; t++) begin
            rn = int'($urandom_range(127, 1)) * 2 + 1;
            rm = int'($urandom_range(rn - 1, 0));
            re = int'($urandom_range(255, 0));
            rr = 65536 % rn;
            run_op($sformatf("rand%0d", t), W'(rm), W'(re), W'(rn), W'(rr),
                   ref_modexp(rm, re, rn), W + $countones(W'(re)) + 3, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter W, default 2048: operand, modulus and exponent width in bits.
REQ-002 Parameter CW, default 12: bit-index counter width; CW SHALL satisfy 2^CW > W.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request; samples M, E, N, R2.
REQ-006 M  input  W  message/base; M < N required.
REQ-007 E  input  W  exponent.
REQ-008 N  input  W  odd modulus.
REQ-009 R2  input  W  precomputed R^2 mod N, where R = 2^W.
REQ-010 C  output  W  result M^E mod N; held until next completion.
REQ-011 done  output  1  one-cycle pulse when C is valid.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 mm_start  output  1  one-cycle start pulse to the downstream Montgomery multiplier.
REQ-014 mm_x, mm_y, mm_n  output  W each  multiplier operands.
REQ-015 mm_o  input  W  multiplier result MM(x,y) = x*y*R^-1 mod N.
REQ-016 mm_done  input  1  multiplier one-cycle completion pulse.

Function
REQ-017 The block SHALL capture M, E, N and R2 into internal registers on the first clk edge where start=1 and the state is IDLE.
REQ-018 start SHALL be ignored while busy=1, with no effect on registers or outputs.
REQ-019 States: IDLE, TOM, TOA, SQR, MUL, FROM, FIN; each non-IDLE/FIN state issues exactly one multiplication.
REQ-020 TOM SHALL compute Mbar = MM(M, R2) and store it.
REQ-021 TOA SHALL compute A = MM(1, R2) = R mod N; bit index i SHALL then be set to W-1.
REQ-022 SQR SHALL compute A = MM(A, A); next state SHALL be MUL if E[i]=1, else i is decremented (or FROM if i=0).
REQ-023 MUL SHALL compute A = MM(A, Mbar); i is then decremented, or the next state is FROM if i=0.
REQ-024 Leading-zero exponent bits SHALL NOT be skipped; the number of multiplications per request SHALL be exactly W + popcount(E) + 3.
REQ-025 FROM SHALL compute C = MM(A, 1); FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 For each multiplication, mm_start SHALL be high for exactly one cycle on entry to the state.
REQ-027 mm_x, mm_y and mm_n SHALL be driven from the cycle mm_start rises and held stable until the cycle after mm_done.
REQ-028 The FSM SHALL wait indefinitely for mm_done; mm_done outside a pending multiplication SHALL be ignored.
REQ-029 mm_o SHALL be latched only in the cycle mm_done=1 for a pending multiplication.
REQ-030 mm_n SHALL always equal the captured N; constant operands 1 are W-bit zero-extended.
REQ-031 E=0 SHALL yield C=1 (for N>1); M=0 with E!=0 SHALL yield C=0.
REQ-032 The next start SHALL be accepted in the cycle after done (IDLE).

Reset
REQ-033 While rst_n=0 at a clk edge: state=IDLE, C=0, done=0, busy=0, mm_start=0, mm_x=mm_y=mm_n=0, i=0, internal A/Mbar=0.
REQ-034 Reset mid-operation SHALL abort the operation with no done pulse; a later mm_done from the aborted multiplication SHALL be ignored.

Verification (W=8, behavioural Montgomery model with variable latency)
REQ-035 M=5, E=3, N=13, R2=3 -> C=8, done pulse once, exactly 13 mm_start pulses.
REQ-036 M=5, E=0, N=13, R2=3 -> C=1, exactly 11 mm_start pulses.
REQ-037 M=0, E=0xFF, N=13, R2=3 -> C=0, exactly 19 mm_start pulses.
REQ-038 start re-pulsed with M=7 while busy -> ignored; C=8 from the original M=5, E=3 request.
REQ-039 rst_n=0 during SQR -> busy=0, no done; a stray mm_done is ignored; a new request M=2, E=5, N=13, R2=3 -> C=6.
REQ-040 Multiplier latency randomized 1-40 cycles -> mm_x, mm_y, mm_n stable while pending; results unchanged.
